// File: rtl/uart_mmio_pkg.sv
// Shared register map, bit positions and TX drain state encoding for the MMIO UART front end.
package uart_mmio_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_BAUD   = 4'h8;
    localparam logic [3:0] REG_CTRL   = 4'hC;

    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_TX_OVERFLOW  = 5;
    localparam int ST_UART_BUSY    = 6;
    localparam int ST_IRQ          = 7;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    localparam int CTRL_RX_IRQ_EN  = 0;
    localparam int CTRL_TX_IRQ_EN  = 1;
    localparam int CTRL_LOOPBACK   = 2;
    localparam int CTRL_TX_CLEAR   = 3;
    localparam int CTRL_RX_CLEAR   = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_WAIT_HI,
        TX_WAIT_LO
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head output; i_clear empties it in a single cycle.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
    import uart_mmio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: TX/RX FIFOs, baud divisor, sticky error flags,
// level interrupt and loopback control between the core data bus and the Uart.
module uart_mmio_fifo
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          TX_DEPTH     = 8,
    parameter int          RX_DEPTH     = 8,
    parameter logic [15:0] BAUD_DEFAULT = 16'h0003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        sel,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_start,
    input  logic        uart_busy,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic [15:0] baud_max,
    output logic        loopback,
    output logic        irq
);

    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    logic [31:0]     w_off;
    logic            w_hit_data, w_hit_status, w_hit_baud, w_hit_ctrl;
    logic            w_wr_data, w_wr_status, w_wr_baud, w_wr_ctrl, w_rd_data;
    logic            w_tx_clr, w_rx_clr;
    logic            w_tx_pop, w_rx_pop;
    logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]      w_tx_head, w_rx_head;
    logic [TXCW-1:0] w_tx_count;
    logic [RXCW-1:0] w_rx_count;
    logic            w_tx_ovf_set, w_rx_ovr_set, w_irq_next;
    logic [31:0]     w_status;
    logic            w_unused_wdata;

    logic [2:0]      r_ctrl;
    logic [15:0]     r_baud;
    logic            r_rx_ovr;
    logic            r_tx_ovf;
    logic            r_irq;
    tx_state_t       r_state;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;

    // Only exact word offsets decode, so sub-word addresses leave sel low.
    assign w_off        = address - BASE_ADDR;
    assign w_hit_data   = (w_off == 32'(REG_DATA));
    assign w_hit_status = (w_off == 32'(REG_STATUS));
    assign w_hit_baud   = (w_off == 32'(REG_BAUD));
    assign w_hit_ctrl   = (w_off == 32'(REG_CTRL));
    assign sel          = w_hit_data | w_hit_status | w_hit_baud | w_hit_ctrl;

    assign w_wr_data    = write_enable & w_hit_data;
    assign w_wr_status  = write_enable & w_hit_status;
    assign w_wr_baud    = write_enable & w_hit_baud;
    assign w_wr_ctrl    = write_enable & w_hit_ctrl;
    assign w_rd_data    = read_enable & w_hit_data;
    assign w_tx_clr     = w_wr_ctrl & write_data[CTRL_TX_CLEAR];
    assign w_rx_clr     = w_wr_ctrl & write_data[CTRL_RX_CLEAR];
    assign w_unused_wdata = ^write_data[31:16];

    assign w_tx_pop     = (r_state == TX_LAUNCH);
    assign w_rx_pop     = w_rd_data & ~w_rx_empty;
    assign w_tx_ovf_set = w_wr_data & w_tx_full & ~w_tx_pop & ~w_tx_clr;
    assign w_rx_ovr_set = uart_rx_valid & w_rx_full & ~w_rx_pop & ~w_rx_clr;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (w_tx_clr),
        .i_push  (w_wr_data),
        .i_data  (write_data[7:0]),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (w_rx_clr),
        .i_push  (uart_rx_valid),
        .i_data  (uart_rx_data),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    assign w_irq_next = (r_ctrl[CTRL_RX_IRQ_EN] & ~w_rx_empty)
                      | (r_ctrl[CTRL_TX_IRQ_EN] & w_tx_empty & (r_state == TX_IDLE))
                      | r_rx_ovr;

    // A new error event in the same cycle as its W1C write keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctrl   <= '0;
            r_baud   <= BAUD_DEFAULT;
            r_rx_ovr <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= write_data[2:0];
            if (w_wr_baud) r_baud <= write_data[15:0];
            if (w_rx_ovr_set)                                   r_rx_ovr <= 1'b1;
            else if (w_wr_status && write_data[ST_RX_OVERRUN])  r_rx_ovr <= 1'b0;
            if (w_tx_ovf_set)                                   r_tx_ovf <= 1'b1;
            else if (w_wr_status && write_data[ST_TX_OVERFLOW]) r_tx_ovf <= 1'b0;
            r_irq <= w_irq_next;
        end
    end

    // A launch is suppressed while the FIFO is being cleared so a flushed byte never leaves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= TX_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (!w_tx_empty && !uart_busy && !w_tx_clr) begin
                        r_state    <= TX_LAUNCH;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_tx_head;
                    end
                end
                TX_LAUNCH:  r_state <= TX_WAIT_HI;
                TX_WAIT_HI: if (uart_busy)  r_state <= TX_WAIT_LO;
                TX_WAIT_LO: if (!uart_busy) r_state <= TX_IDLE;
                default:    r_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        w_status                              = '0;
        w_status[ST_RX_NONEMPTY]              = ~w_rx_empty;
        w_status[ST_RX_FULL]                  = w_rx_full;
        w_status[ST_TX_EMPTY]                 = w_tx_empty;
        w_status[ST_TX_FULL]                  = w_tx_full;
        w_status[ST_RX_OVERRUN]               = r_rx_ovr;
        w_status[ST_TX_OVERFLOW]              = r_tx_ovf;
        w_status[ST_UART_BUSY]                = uart_busy;
        w_status[ST_IRQ]                      = r_irq;
        w_status[ST_RX_COUNT_LSB +: 8]        = 8'(w_rx_count);
        w_status[ST_TX_COUNT_LSB +: 8]        = 8'(w_tx_count);
    end

    always_comb begin
        read_data = '0;
        if (w_hit_data)        read_data = {24'b0, (w_rx_empty ? 8'h00 : w_rx_head)};
        else if (w_hit_status) read_data = w_status;
        else if (w_hit_baud)   read_data = {16'b0, r_baud};
        else if (w_hit_ctrl)   read_data = {29'b0, r_ctrl};
    end

    assign uart_tx_start = r_tx_start;
    assign uart_tx_data  = r_tx_data;
    assign baud_max      = r_baud;
    assign loopback      = r_ctrl[CTRL_LOOPBACK];
    assign irq           = r_irq;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: directed register scenarios plus randomized bus/RX traffic
// compared against a queue-based reference model; a small Uart model answers launches.
`timescale 1ns/1ps
module tb_uart_mmio_fifo;

    localparam logic [31:0] BASE     = 32'h10010000;
    localparam int          DEPTH    = 8;
    localparam int          BUSY_CYC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        sel;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_start;
    logic        uart_busy;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic [15:0] baud_max;
    logic        loopback;
    logic        irq;

    logic        hold_busy = 1'b0;
    logic        model_busy = 1'b0;
    logic        stim_rx_valid = 1'b0;
    logic [7:0]  stim_rx_data = '0;
    logic        lb_valid = 1'b0;
    logic [7:0]  lb_data = '0;

    assign uart_busy     = hold_busy | model_busy;
    assign uart_rx_valid = stim_rx_valid | lb_valid;
    assign uart_rx_data  = lb_valid ? lb_data : stim_rx_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  sent_q[$];
    int          sent_cyc[$];
    logic [7:0]  um_b;
    logic        um_lb;

    // reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic        m_ovr, m_ovf, m_irq, nxt_irq;
    logic [15:0] m_baud;

    logic [31:0] d;
    int          op, n0, w0;
    logic        rxv;
    logic [7:0]  rxd;
    logic [31:0] wd;
    logic [3:0]  off;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_mmio_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .sel          (sel),
        .uart_tx_data (uart_tx_data),
        .uart_tx_start(uart_tx_start),
        .uart_busy    (uart_busy),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .baud_max     (baud_max),
        .loopback     (loopback),
        .irq          (irq)
    );

    // Uart model: busy for BUSY_CYC cycles after each launch, echoes the byte back in loopback
    initial begin
        forever begin
            @(negedge clk);
            if (uart_tx_start) begin
                um_b  = uart_tx_data;
                um_lb = loopback;
                sent_q.push_back(um_b);
                sent_cyc.push_back(cyc);
                model_busy = 1'b1;
                repeat (BUSY_CYC) @(negedge clk);
                model_busy = 1'b0;
                if (um_lb) begin
                    lb_data  = um_b;
                    lb_valid = 1'b1;
                    @(negedge clk);
                    lb_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] o, input logic [31:0] v);
        address      = BASE + 32'(o);
        write_data   = v;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] o, output logic [31:0] v);
        address     = BASE + 32'(o);
        read_enable = 1'b1;
        @(negedge clk);
        v = read_data;
        step();
        read_enable = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        stim_rx_data  = b;
        stim_rx_valid = 1'b1;
        step();
        stim_rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (rxq.size() != 0);
        s[1]     = (rxq.size() == DEPTH);
        s[2]     = (txq.size() == 0);
        s[3]     = (txq.size() == DEPTH);
        s[4]     = m_ovr;
        s[5]     = m_ovf;
        s[6]     = uart_busy;
        s[7]     = m_irq;
        s[15:8]  = 8'(rxq.size());
        s[23:16] = 8'(txq.size());
        return s;
    endfunction

    function automatic logic [31:0] sent_at(input int k);
        return (k < sent_q.size()) ? 32'(sent_q[k]) : 32'hDEAD;
    endfunction

    initial begin
        // reset and register defaults
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        check("rst_irq", 32'(irq), 0);
        check("rst_tx_start", 32'(uart_tx_start), 0);
        check("rst_loopback", 32'(loopback), 0);
        check("rst_baud_pin", 32'(baud_max), 32'h3);
        bus_rd(4'h4, d);  check("rst_status", d, 32'h00000004);
        bus_rd(4'h8, d);  check("rst_baud", d, 32'h00000003);
        address = BASE + 32'h1; #1;
        check("sel_misaligned", 32'(sel), 0);
        check("rd_unselected", read_data, 0);
        address = BASE + 32'hC; #1;
        check("sel_ctrl", 32'(sel), 1);

        // three bytes drained through the Uart model
        w0 = cyc;
        bus_wr(4'h0, 32'h41);
        bus_wr(4'h0, 32'h42);
        bus_wr(4'h0, 32'h43);
        for (int i = 0; i < 200 && !(sent_q.size() == 3 && !model_busy); i++) step();
        check("tx3_count", 32'(sent_q.size()), 3);
        check("tx3_byte0", sent_at(0), 32'h41);
        check("tx3_byte1", sent_at(1), 32'h42);
        check("tx3_byte2", sent_at(2), 32'h43);
        check("tx_latency", (sent_cyc.size() > 0) ? 32'(sent_cyc[0] - w0) : 32'hFFFF_FFFF, 2);
        step(); step();
        bus_rd(4'h4, d);  check("tx3_status", d, 32'h00000004);

        // randomized bus and RX traffic with the transmitter held busy
        hold_busy = 1'b1;
        m_ovr = 0; m_ovf = 0; m_irq = 0; m_baud = 16'h0003;
        txq.delete(); rxq.delete();
        for (int it = 0; it < 500; it++) begin
            op  = $urandom_range(0, 11);
            rxv = ($urandom_range(0, 2) == 0);
            rxd = 8'($urandom);
            wd  = $urandom;
            case (op)
                0, 1, 2, 3, 4: off = 4'h0;
                5, 6:          off = 4'h4;
                7, 8:          off = 4'h8;
                9:             off = 4'hC;
                default:       off = 4'h0;
            endcase
            if (op == 9) wd = 32'h18;
            address       = BASE + 32'(off);
            write_data    = wd;
            write_enable  = (op <= 2) || op == 6 || op == 7 || op == 9;
            read_enable   = (op == 3) || op == 4 || op == 5 || op == 8;
            stim_rx_valid = rxv;
            stim_rx_data  = rxd;
            @(negedge clk);
            check("rnd_irq", 32'(irq), 32'(m_irq));
            check("rnd_baud_pin", 32'(baud_max), 32'(m_baud));
            if (op == 3 || op == 4) check("rnd_data", read_data, (rxq.size() != 0) ? 32'(rxq[0]) : 0);
            if (op == 5) check("rnd_status", read_data, exp_status());
            if (op == 8) check("rnd_baud", read_data, 32'(m_baud));
            step();
            write_enable  = 1'b0;
            read_enable   = 1'b0;
            stim_rx_valid = 1'b0;
            nxt_irq = m_ovr;
            if (op == 6) begin
                if (wd[4]) m_ovr = 0;
                if (wd[5]) m_ovf = 0;
            end
            if (op == 9) begin
                txq.delete();
                rxq.delete();
            end else begin
                if ((op == 3 || op == 4) && rxq.size() != 0) void'(rxq.pop_front());
                if (rxv) begin
                    if (rxq.size() < DEPTH) rxq.push_back(rxd);
                    else m_ovr = 1;
                end
                if (op <= 2) begin
                    if (txq.size() < DEPTH) txq.push_back(wd[7:0]);
                    else m_ovf = 1;
                end
            end
            if (op == 7) m_baud = wd[15:0];
            m_irq = nxt_irq;
        end
        // release the transmitter and compare the drained bytes with the model queue
        n0 = sent_q.size();
        hold_busy = 1'b0;
        for (int i = 0; i < 400 && !(sent_q.size() == n0 + txq.size() && !model_busy); i++) step();
        check("rnd_drain_count", 32'(sent_q.size() - n0), 32'(txq.size()));
        for (int k = 0; k < txq.size(); k++) check("rnd_drain_byte", sent_at(n0 + k), 32'(txq[k]));
        bus_wr(4'hC, 32'h18);
        bus_wr(4'h4, 32'h30);
        step();
        bus_rd(4'h4, d);  check("rnd_cleanup_status", d, 32'h00000004);

        // TX overflow with the transmitter held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) bus_wr(4'h0, 32'(8'h60 + i));
        bus_rd(4'h4, d);  check("ovf_status", d, 32'h00080068);
        bus_wr(4'h4, 32'h20);
        bus_rd(4'h4, d);  check("ovf_w1c", d, 32'h00080048);
        bus_wr(4'hC, 32'h08);
        bus_rd(4'h4, d);  check("tx_clear_status", d, 32'h00000044);

        // RX overrun, simultaneous pop/push when full, drain order
        for (int i = 0; i < 9; i++) rx_pulse(8'(8'h10 + i));
        step();
        check("ovr_irq", 32'(irq), 1);
        bus_rd(4'h4, d);  check("ovr_status", d, 32'h000008D7);
        address = BASE; read_enable = 1'b1; stim_rx_data = 8'h55; stim_rx_valid = 1'b1;
        @(negedge clk);
        d = read_data;
        step();
        read_enable = 1'b0; stim_rx_valid = 1'b0;
        check("full_poppush_data", d, 32'h10);
        bus_rd(4'h4, d);  check("full_poppush_status", d, 32'h000008D7);
        for (int i = 1; i < 8; i++) begin
            bus_rd(4'h0, d);  check("rx_drain", d, 32'(8'h10 + i));
        end
        bus_rd(4'h0, d);  check("rx_drain_last", d, 32'h55);
        bus_rd(4'h0, d);  check("rx_empty_read", d, 32'h0);
        bus_wr(4'h4, 32'h10);
        step();
        check("ovr_irq_cleared", 32'(irq), 0);
        // pop and push together while empty
        address = BASE; read_enable = 1'b1; stim_rx_data = 8'h66; stim_rx_valid = 1'b1;
        @(negedge clk);
        d = read_data;
        step();
        read_enable = 1'b0; stim_rx_valid = 1'b0;
        check("empty_poppush_data", d, 32'h0);
        bus_rd(4'h4, d);  check("empty_poppush_status", d, 32'h00000145);
        bus_rd(4'h0, d);  check("empty_poppush_byte", d, 32'h66);

        // loopback with RX interrupt
        hold_busy = 1'b0;
        bus_wr(4'hC, 32'h05);
        check("loopback_pin", 32'(loopback), 1);
        bus_rd(4'hC, d);  check("ctrl_read", d, 32'h05);
        n0 = sent_q.size();
        bus_wr(4'h0, 32'h7E);
        for (int i = 0; i < 100 && !(sent_q.size() > n0 && !model_busy && !lb_valid); i++) step();
        step(); step();
        check("lb_irq", 32'(irq), 1);
        bus_rd(4'h0, d);  check("lb_data", d, 32'h7E);
        // both FIFOs emptied by one CTRL write
        hold_busy = 1'b1;
        bus_wr(4'h0, 32'h01);
        bus_wr(4'h0, 32'h02);
        rx_pulse(8'hA1);
        rx_pulse(8'hA2);
        bus_wr(4'hC, 32'h18);
        bus_rd(4'h4, d);  check("clear_both", d & 32'h00FFFF0F, 32'h00000004);
        check("loopback_off", 32'(loopback), 0);
        bus_rd(4'hC, d);  check("ctrl_pulse_bits", d, 32'h0);

        // TX-empty interrupt
        bus_wr(4'hC, 32'h02);
        step();
        check("txe_irq", 32'(irq), 1);
        bus_wr(4'h0, 32'h33);
        step();
        check("txe_irq_off", 32'(irq), 0);
        bus_wr(4'hC, 32'h08);

        // tx_clear while a byte is in flight
        hold_busy = 1'b0;
        step();
        n0 = sent_q.size();
        bus_wr(4'h0, 32'hA1);
        bus_wr(4'h0, 32'hA2);
        bus_wr(4'h0, 32'hA3);
        step(); step();
        check("inflight_busy", 32'(uart_busy), 1);
        bus_wr(4'hC, 32'h08);
        repeat (40) step();
        check("inflight_count", 32'(sent_q.size() - n0), 1);
        check("inflight_byte", sent_at(n0), 32'hA1);
        bus_rd(4'h4, d);  check("inflight_status", d, 32'h00000004);

        // reset mid-frame
        bus_wr(4'h8, 32'h1234);
        n0 = sent_q.size();
        bus_wr(4'h0, 32'hB1);
        bus_wr(4'h0, 32'hB2);
        step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_start", 32'(uart_tx_start), 0);
        check("midrst_baud", 32'(baud_max), 32'h3);
        bus_rd(4'h4, d);  check("midrst_status", d, 32'h00000044);
        repeat (30) step();
        check("midrst_sent", 32'(sent_q.size() - n0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
Memory-mapped UART front end sitting between Core's data bus and the existing Uart serializer/deserializer. It replaces the single-byte tx/rx holding registers with parametrised TX and RX FIFOs, adds a programmable baud divisor, sticky error flags, interrupt generation and a loopback control. Top instantiates it beside DMemory and muxes its read_data in when `sel` is high.

Parameters:
BASE_ADDR, 32'h10010000, byte address of register 0; the block decodes BASE_ADDR+0x0/0x4/0x8/0xC.
TX_DEPTH, 8, TX FIFO entries; power of two, 2..256.
RX_DEPTH, 8, RX FIFO entries; power of two, 2..256.
BAUD_DEFAULT, 16'h0003, baud_max value after reset.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset; state clears on the rising clk edge while rst==0
address  in  32  bus byte address
write_data  in  32  bus write data
write_enable  in  1  bus write strobe, one cycle per access
read_enable  in  1  bus read strobe, one cycle per access
read_data  out  32  combinational register read data; 0 when sel==0
sel  out  1  address hits one of the four registers
uart_tx_data  out  8  byte to Uart
uart_tx_start  out  1  one-cycle launch pulse to Uart write_enable
uart_busy  in  1  Uart transmitter busy
uart_rx_data  in  8  received byte from Uart
uart_rx_valid  in  1  one-cycle received-byte strobe (Uart outValid)
baud_max  out  16  divisor to Uart
loopback  out  1  Top routes Uart tx into rx when high
irq  out  1  level interrupt

Behaviour:
- Registers:
  - 0x0 DATA: a write pushes write_data[7:0] to TX. A read returns RX head in [7:0] and pops it when read_enable is high; an empty RX returns 0 with no pop.
  - 0x4 STATUS (read): [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_overrun, [5] tx_overflow, [6] uart_busy, [7] irq, [15:8] rx_count, [23:16] tx_count. Writing 1 to [4]/[5] clears that bit (W1C).
  - 0x8 BAUD: [15:0] read/write.
  - 0xC CTRL: [0] rx_irq_en, [1] tx_empty_irq_en, [2] loopback, RW. [3] tx_clear and [4] rx_clear are write-1 self-clearing pulses that empty the FIFO in the same cycle; both read as 0.
- Reset values: all FIFOs empty, counts 0, sticky flags 0, CTRL 0, baud_max=BAUD_DEFAULT, uart_tx_start=0, uart_tx_data=0, irq=0, loopback=0.
- TX FIFO full and DATA written: the byte is dropped and tx_overflow is set.
- RX push on uart_rx_valid:
  - RX full: the byte is dropped and rx_overrun is set.
  - Same-cycle pop and push while full: both occur, count is unchanged, no overrun.
  - Same-cycle pop and push while empty: the pop returns 0, the push lands, count becomes 1.
- TX drain FSM:
  - TX_IDLE: TX non-empty and uart_busy==0 -> TX_LAUNCH.
  - TX_LAUNCH: one cycle; uart_tx_start=1, uart_tx_data=head, pop -> TX_WAIT_HI.
  - TX_WAIT_HI: wait for uart_busy==1 -> TX_WAIT_LO.
  - TX_WAIT_LO: wait for uart_busy==0 -> TX_IDLE.
  - Latency from DATA write into an idle, empty FIFO to uart_tx_start: 2 cycles.
- tx_clear during TX_WAIT_*: the in-flight byte completes; the FSM returns to TX_IDLE with an empty FIFO.
- irq = (rx_irq_en & rx_nonempty) | (tx_empty_irq_en & tx_empty & FSM==TX_IDLE) | rx_overrun. It is registered, 1-cycle lag.
- Counters are $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH. Counts are zero-extended into the 8-bit STATUS fields; DEPTH=256 reads full as 0 with the full bit set.
- Reset asserted mid-frame: the FSM goes to TX_IDLE immediately. The Uart frame in flight is Uart's concern.
- Byte lanes: only word-aligned addresses decode. Sub-word offsets give sel=0.

Decomposition:
- uart_mmio_pkg holds:
  - register offsets (REG_DATA, REG_STATUS, REG_BAUD, REG_CTRL);
  - STATUS/CTRL bit-index localparams;
  - tx_state_t enum {TX_IDLE, TX_LAUNCH, TX_WAIT_HI, TX_WAIT_LO}.
- Sub-module sync_fifo (params WIDTH, DEPTH) with push/pop/clear/full/empty/count, instantiated twice.

Test Plan:
- Reset with rst=0 for 2 cycles -> STATUS reads 32'h00000004 (tx_empty only), BAUD reads 32'h00000003, irq=0.
- Write 0x41,0x42,0x43 to DATA, Uart model busy 10 cycles per byte -> uart_tx_start pulses three times carrying 0x41,0x42,0x43 in order; the first pulse comes 2 cycles after the first write; tx_empty is set afterwards.
- Write 9 bytes with uart_busy held high (TX_DEPTH=8) -> tx_full=1, tx_count=8, tx_overflow=1; a write of 0x20 to STATUS clears tx_overflow.
- Pulse uart_rx_valid with 0x10..0x18 (9 bytes) -> rx_count=8, rx_overrun=1, irq=1; reading DATA 8 times returns 0x10..0x17; a 9th read returns 0.
- With RX full, drive a DATA read and uart_rx_valid (0x55) in the same cycle -> rx_count stays 8, rx_overrun unchanged, 0x55 is read last.
- CTRL write 0x05 (loopback, rx_irq_en), then write 0x7E to DATA -> loopback=1; after the frame, irq=1 and DATA reads 0x7E. CTRL write 0x18 -> both FIFOs are empty next cycle.
